// File: rtl/rd_word_packer.sv
// rd_word_packer
//   Read-domain consumer for the asynchronous FIFO. Pops bytes from a
//   first-word-fall-through read port and packs PACK consecutive bytes
//   into one wide word held in a valid/ready output register. The first
//   popped byte lands in lane 0 (LSBs).
//
//   Optional feature (compile-time macro RD_PACK_FLUSH_EN): a single-cycle
//   flush request emits the partially filled word with byte enables. Without
//   the macro the flush input is ignored and out_be is always all ones.
//
// Parameters
//   DATASIZE  lane width in bits (FIFO data width)
//   PACK      lanes per output word, 2..8
//   CNTW      width of the accepted-word counter
//
// Ports
//   r_clk      read-domain clock
//   r_rst      asynchronous active-high reset
//   rempty     FIFO empty flag
//   rdata      FIFO head data, valid while rempty=0
//   r_inc      pop strobe to the FIFO (combinational)
//   flush      request to emit a partial word (RD_PACK_FLUSH_EN only)
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word when out_valid & out_ready
//   out_data   packed word
//   out_be     lane enables
//   words_out  count of accepted words, wraps
//   busy       partial lanes held, word held, or flush pending
module rd_word_packer #(
  parameter int DATASIZE = 8,
  parameter int PACK     = 4,
  parameter int CNTW     = 16
) (
  input  logic                     r_clk,
  input  logic                     r_rst,
  input  logic                     rempty,
  input  logic [DATASIZE-1:0]      rdata,
  output logic                     r_inc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATASIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]          out_be,
  output logic [CNTW-1:0]          words_out,
  output logic                     busy
);

  localparam int CW = $clog2(PACK);
  localparam logic [CW-1:0] LAST = CW'(PACK - 1);

  typedef enum logic {FILL, FLUSH_PEND} state_t;

  state_t                        r_state;
  logic [CW-1:0]                 r_cnt;
  logic [(PACK-1)*DATASIZE-1:0]  r_acc;

  logic                          w_flush_req;
  logic                          w_flush_pend;
  logic                          w_drain;
  logic                          w_room;
  logic                          w_last;
  logic [CW-1:0]                 w_cnt_nxt;
  logic [DATASIZE*PACK-1:0]      w_part_data;
  logic [PACK-1:0]               w_part_be;

`ifdef RD_PACK_FLUSH_EN
  assign w_flush_req = flush;
`else
  logic w_flush_unused;
  assign w_flush_unused = flush;
  assign w_flush_req    = 1'b0;
`endif

  assign w_flush_pend = (r_state == FLUSH_PEND);
  assign w_drain      = out_valid & out_ready;
  // The output register can take a new word if it is empty or draining now.
  assign w_room       = !out_valid | out_ready;
  assign w_last       = (r_cnt == LAST);

  // Only the lane that completes a word needs room in the output register.
  assign r_inc = !r_rst & !rempty & !w_flush_pend & (!w_last | w_room);

  // Lane count after this edge's pop; a flush that coincides with the pop
  // completing a word has nothing left to emit.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_inc) w_cnt_nxt = w_last ? '0 : r_cnt + CW'(1);
  end

  // Partial word: lanes at or above cnt may hold stale bytes, so zero them.
  always_comb begin
    w_part_data = '0;
    w_part_be   = '0;
    for (int i = 0; i < PACK - 1; i++) begin
      if (i < int'(r_cnt)) begin
        w_part_data[i*DATASIZE +: DATASIZE] = r_acc[i*DATASIZE +: DATASIZE];
        w_part_be[i]                        = 1'b1;
      end
    end
  end

  assign busy = (r_cnt != '0) | out_valid | w_flush_pend;

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_state   <= FILL;
      r_cnt     <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_be    <= '0;
      words_out <= '0;
    end else begin
      if (w_drain) begin
        words_out <= words_out + CNTW'(1);
        // A reload below on the same edge overrides this clear.
        out_valid <= 1'b0;
      end
      case (r_state)
        FILL: begin
          if (r_inc) begin
            if (w_last) begin
              out_data  <= {rdata, r_acc};
              out_be    <= '1;
              out_valid <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_acc[r_cnt*DATASIZE +: DATASIZE] <= rdata;
              r_cnt <= r_cnt + CW'(1);
            end
          end
          if (w_flush_req && (w_cnt_nxt != '0)) r_state <= FLUSH_PEND;
        end
        FLUSH_PEND: begin
          if (w_room) begin
            if (r_cnt != '0) begin
              out_data  <= w_part_data;
              out_be    <= w_part_be;
              out_valid <= 1'b1;
            end
            r_cnt   <= '0;
            r_state <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_word_packer.sv
module tb_rd_word_packer;

  localparam int DW   = 8;
  localparam int PACK = 4;
  localparam int CNTW = 4;

  logic                 r_clk = 1'b0;
  logic                 r_rst;
  logic                 rempty;
  logic [DW-1:0]        rdata;
  logic                 r_inc;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW*PACK-1:0]   out_data;
  logic [PACK-1:0]      out_be;
  logic [CNTW-1:0]      words_out;
  logic                 busy;

  rd_word_packer #(.DATASIZE(DW), .PACK(PACK), .CNTW(CNTW)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .rempty(rempty), .rdata(rdata),
    .r_inc(r_inc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_be(out_be),
    .words_out(words_out), .busy(busy)
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  be;
  } word_t;

  typedef struct {
    int         nbytes;
    logic [7:0] base;
    bit         stall;
    logic       exp_busy;
  } vec_t;

  logic [7:0]  fifo[$];
  logic [7:0]  pend[$];
  word_t       exp_q[$];
  logic [3:0]  exp_wo;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pops;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    rempty = (fifo.size() == 0);
    rdata  = (fifo.size() == 0) ? 8'h00 : fifo[0];
  endtask

  // Model: every PACK bytes offered become one expected full word.
  task automatic add_byte(input logic [7:0] b);
    word_t w;
    fifo.push_back(b);
    pend.push_back(b);
    if (pend.size() == PACK) begin
      w.d  = {pend[3], pend[2], pend[1], pend[0]};
      w.be = 4'hF;
      exp_q.push_back(w);
      pend.delete();
    end
    drive_fifo();
  endtask

  task automatic clear_model();
    fifo.delete();
    pend.delete();
    exp_q.delete();
    exp_wo = '0;
    drive_fifo();
  endtask

  // One clock: sample at the falling edge, update the FIFO model after the rise.
  task automatic tick();
    logic  pop;
    word_t w;
    @(negedge r_clk);
    pop = r_inc;
    if (pop && rempty) check("pop_while_empty", 1, 0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %0h want none", out_data);
      end else begin
        w = exp_q.pop_front();
        check("word_data", out_data, w.d);
        check("word_be", out_be, w.be);
      end
      exp_wo = exp_wo + 4'd1;
    end
    @(posedge r_clk);
    #1;
    if (pop) begin
      if (fifo.size() != 0) void'(fifo.pop_front());
      n_pops++;
    end
    drive_fifo();
  endtask

  task automatic do_reset();
    r_rst = 1'b1;
    clear_model();
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    r_rst = 1'b0;
    @(posedge r_clk);
    #1;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{nbytes: 8,  base: 8'h01, stall: 1'b0, exp_busy: 1'b0};
    vecs[1] = '{nbytes: 12, base: 8'h10, stall: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{nbytes: 6,  base: 8'h20, stall: 1'b0, exp_busy: 1'b1};
    vecs[3] = '{nbytes: 2,  base: 8'h30, stall: 1'b0, exp_busy: 1'b0};

    r_rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    clear_model();
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    do_reset();

    // Reset mid-word with a held output word and two partial lanes.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) add_byte(8'hC0 + 8'(i));
    repeat (8) tick();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_busy", busy, 1);
    add_byte(8'hEE);
    #2;
    r_rst = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_be", out_be, 0);
    check("rst_words", words_out, 0);
    check("rst_busy_mid", busy, 0);
    check("rst_inc", r_inc, 0);
    do_reset();

    // Table of streams; the model carries partial lanes between entries.
    for (int v = 0; v < 4; v++) begin
      n_pops = 0;
      out_ready = 1'b1;
      for (int i = 0; i < vecs[v].nbytes; i++) add_byte(vecs[v].base + 8'(i));
      for (int c = 0; c < vecs[v].nbytes * 3 + 20; c++) begin
        out_ready = vecs[v].stall ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
      end
      out_ready = 1'b1;
      repeat (5) tick();
      check("vec_pops", n_pops, vecs[v].nbytes);
      check("vec_words_out", words_out, exp_wo);
      check("vec_missing_words", exp_q.size(), 0);
      check("vec_busy", busy, vecs[v].exp_busy);
      check("vec_inc_idle", r_inc, 0);
    end

    // Backpressure: first word held stable, pops stall after seven bytes.
    n_pops = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) add_byte(8'h40 + 8'(i));
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c >= 4) check("bp_hold_data", out_data, 32'h43424140);
    end
    check("bp_pops", n_pops, 7);
    check("bp_valid", out_valid, 1);
    check("bp_inc_stall", r_inc, 0);
    out_ready = 1'b1;
    repeat (20) tick();
    check("bp_pops_total", n_pops, 12);
    check("bp_words_out", words_out, exp_wo);
    check("bp_missing", exp_q.size(), 0);
    check("bp_busy", busy, 0);

    // Counter wrap: 17 accepted words on a 4-bit counter.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17 * PACK; i++) add_byte(8'(i * 3 + 1));
    repeat (17 * PACK + 10) tick();
    check("wrap_words_out", words_out, 4'd1);
    check("wrap_missing", exp_q.size(), 0);

`ifdef RD_PACK_FLUSH_EN
    // Partial flush of two lanes, then a flush with nothing to emit.
    out_ready = 1'b1;
    add_byte(8'hAA);
    add_byte(8'hBB);
    repeat (4) tick();
    check("fl_busy_partial", busy, 1);
    flush = 1'b1;
    pend.delete();
    exp_q.push_back('{d: 32'h0000BBAA, be: 4'h3});
    tick();
    flush = 1'b0;
    repeat (5) tick();
    check("fl_missing", exp_q.size(), 0);
    check("fl_words_out", words_out, exp_wo);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    check("fl_empty_valid", out_valid, 0);
    check("fl_empty_words", words_out, exp_wo);
    check("fl_empty_busy", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
